dict_finder: RTL and testbench

DICT_FINDER -- requirements
Module: dict_finder

---
 rtl/dict_finder_if.sv | 12 +
 rtl/dict_finder.sv | 208 ++++++++++++++++++++
 tb/tb_dict_finder.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dict_finder_if.sv
// 8-bit byte-wide memory read bus between dict_finder (master) and its memory.
// The master drives address ai and write strobe we; the memory returns vo combinationally.
interface mb8_io #(
  parameter int ASZ = 17
) ();
  logic [ASZ-1:0] ai;
  logic           we;
  logic [7:0]     vo;

  modport master (output ai, output we, input vo);
  modport slave  (input ai, input we, output vo);
endinterface

// File: rtl/dict_finder.sv
// Dictionary search: scans a blank/NUL-delimited token, then walks the linked dictionary
// from ctx toward older entries. Macro FINDER_ICASE_EN makes name compares ASCII case-insensitive.
module dict_finder #(
  parameter int          ASZ     = 17,
  parameter int unsigned NUL_LNK = 'hffff
) (
  input  logic           clk,
  input  logic           rst,
  mb8_io.master          b8_if,
  input  logic           en,
  input  logic [ASZ-1:0] tkn,
  input  logic [ASZ-1:0] ctx,
  output logic           bsy,
  output logic           done,
  output logic           hit,
  output logic [ASZ-1:0] pfa,
  output logic [7:0]     op,
  output logic [7:0]     tlen,
  output logic [ASZ-1:0] nxt,
  output logic [3:0]     dbg_state
);
  typedef enum logic [3:0] {
    IDLE, TSCAN, LNK_LO, LNK_HI, LEN, CMP_N, CMP_T, OPC, FIN
  } state_t;

  localparam logic [15:0]    NUL16 = 16'(NUL_LNK);
  localparam logic [ASZ-1:0] NULA  = ASZ'(NUL_LNK);

  state_t         state_q, state_d;
  logic [ASZ-1:0] ai_q, ai_d;
  logic [ASZ-1:0] tkn_q, tkn_d;
  logic [ASZ-1:0] cur_q, cur_d;
  logic [15:0]    lnk_q, lnk_d;
  logic [7:0]     lo_q, lo_d;
  logic [7:0]     idx_q, idx_d;
  logic [7:0]     nb_q, nb_d;
  logic           hit_q, hit_d;
  logic [ASZ-1:0] pfa_q, pfa_d;
  logic [7:0]     op_q, op_d;
  logic [7:0]     tlen_q, tlen_d;
  logic [ASZ-1:0] nxt_q, nxt_d;
  logic           scan_end;
  logic [7:0]     scan_len;
  logic           go_next;

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef FINDER_ICASE_EN
    fold = (b >= 8'h41 && b <= 8'h5a) ? (b | 8'h20) : b;
`else
    fold = b;
`endif
  endfunction

  // Handshake: en is a one-cycle request honoured only in IDLE (ignored while bsy);
  // completion is signalled by the single-cycle done pulse, results held until next accept.
  always_comb begin
    state_d  = state_q;
    ai_d     = ai_q;
    tkn_d    = tkn_q;
    cur_d    = cur_q;
    lnk_d    = lnk_q;
    lo_d     = lo_q;
    idx_d    = idx_q;
    nb_d     = nb_q;
    hit_d    = hit_q;
    pfa_d    = pfa_q;
    op_d     = op_q;
    tlen_d   = tlen_q;
    nxt_d    = nxt_q;
    scan_end = 1'b0;
    scan_len = tlen_q;
    go_next  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          tkn_d   = tkn;
          cur_d   = ctx;
          ai_d    = tkn;
          tlen_d  = '0;
          nxt_d   = '0;
          hit_d   = 1'b0;
          pfa_d   = '0;
          op_d    = '0;
          state_d = TSCAN;
        end
      end
      TSCAN: begin
        if (b8_if.vo == 8'h20 || b8_if.vo == 8'h00) begin
          nxt_d    = ai_q;
          scan_end = 1'b1;
        end else if (tlen_q == 8'd254) begin
          tlen_d   = 8'd255;
          scan_len = 8'd255;
          nxt_d    = ai_q + ASZ'(1);
          scan_end = 1'b1;
        end else begin
          tlen_d = tlen_q + 8'd1;
          ai_d   = ai_q + ASZ'(1);
        end
        if (scan_end) begin
          if (scan_len == 8'd0 || cur_q == NULA) begin
            state_d = FIN;
          end else begin
            ai_d    = cur_q;
            state_d = LNK_LO;
          end
        end
      end
      LNK_LO: begin
        lo_d    = b8_if.vo;
        ai_d    = cur_q + ASZ'(1);
        state_d = LNK_HI;
      end
      LNK_HI: begin
        lnk_d   = {b8_if.vo, lo_q};
        ai_d    = cur_q + ASZ'(2);
        state_d = LEN;
      end
      LEN: begin
        if (b8_if.vo != tlen_q) begin
          go_next = 1'b1;
        end else begin
          idx_d   = '0;
          ai_d    = cur_q + ASZ'(3);
          state_d = CMP_N;
        end
      end
      CMP_N: begin
        nb_d    = b8_if.vo;
        ai_d    = tkn_q + ASZ'(idx_q);
        state_d = CMP_T;
      end
      CMP_T: begin
        if (fold(nb_q) != fold(b8_if.vo)) begin
          go_next = 1'b1;
        end else if (idx_q == tlen_q - 8'd1) begin
          pfa_d   = cur_q + ASZ'(3) + ASZ'(tlen_q);
          ai_d    = cur_q + ASZ'(3) + ASZ'(tlen_q);
          state_d = OPC;
        end else begin
          idx_d   = idx_q + 8'd1;
          ai_d    = cur_q + ASZ'(3) + ASZ'(idx_q) + ASZ'(1);
          state_d = CMP_N;
        end
      end
      OPC: begin
        op_d    = b8_if.vo;
        hit_d   = 1'b1;
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Advance to the older entry, or end with a miss at the chain terminator.
    if (go_next) begin
      if (lnk_q == NUL16) begin
        state_d = FIN;
      end else begin
        cur_d   = ASZ'(lnk_q);
        ai_d    = ASZ'(lnk_q);
        state_d = LNK_LO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ai_q    <= '0;
      tkn_q   <= '0;
      cur_q   <= '0;
      lnk_q   <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
      nb_q    <= '0;
      hit_q   <= 1'b0;
      pfa_q   <= '0;
      op_q    <= '0;
      tlen_q  <= '0;
      nxt_q   <= '0;
    end else begin
      state_q <= state_d;
      ai_q    <= ai_d;
      tkn_q   <= tkn_d;
      cur_q   <= cur_d;
      lnk_q   <= lnk_d;
      lo_q    <= lo_d;
      idx_q   <= idx_d;
      nb_q    <= nb_d;
      hit_q   <= hit_d;
      pfa_q   <= pfa_d;
      op_q    <= op_d;
      tlen_q  <= tlen_d;
      nxt_q   <= nxt_d;
    end
  end

  assign b8_if.ai  = ai_q;
  assign b8_if.we  = 1'b0;
  assign bsy       = (state_q != IDLE) && (state_q != FIN);
  assign done      = (state_q == FIN);
  assign hit       = hit_q;
  assign pfa       = pfa_q;
  assign op        = op_q;
  assign tlen      = tlen_q;
  assign nxt       = nxt_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_dict_finder.sv
// Bench for dict_finder: preloaded dictionary/TIB, directed cases plus randomized tokens
// checked against a behavioural search model.
`timescale 1ns/1ps
module tb_dict_finder;
  localparam int ASZ = 17;

  typedef struct packed {
    logic           hit;
    logic [ASZ-1:0] pfa;
    logic [7:0]     op;
    logic [7:0]     tlen;
    logic [ASZ-1:0] nxt;
  } res_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [ASZ-1:0] tkn_i, ctx_i;
  logic           bsy, done, hit;
  logic [ASZ-1:0] pfa, nxt;
  logic [7:0]     op, tlen;
  logic [3:0]     dbg_state;

  logic [7:0] mem [0:(1<<ASZ)-1];
  mb8_io #(.ASZ(ASZ)) bus ();
  assign bus.vo = mem[bus.ai];

  dict_finder #(.ASZ(ASZ), .NUL_LNK('hffff)) dut (
    .clk(clk), .rst(rst), .b8_if(bus), .en(en), .tkn(tkn_i), .ctx(ctx_i),
    .bsy(bsy), .done(done), .hit(hit), .pfa(pfa), .op(op), .tlen(tlen),
    .nxt(nxt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int we_high = 0;
  int dict_rd = 0;

  always @(negedge clk) begin
    if (bus.we !== 1'b0) we_high++;
    if (bsy === 1'b1 && bus.ai >= 17'h100 && bus.ai < 17'h130) dict_rd++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- memory image ----------------
  string       names [6] = '{"nop", "dup", "drop", "swap", "+", "-"};
  logic [16:0] ents  [7] = '{17'h100, 17'h107, 17'h10E, 17'h116, 17'h11E, 17'h123, 17'h0ffff};

  task automatic add_entry(input int addr, input int link, input string nm);
    mem[addr]   = 8'(link);
    mem[addr+1] = 8'(link >> 8);
    mem[addr+2] = 8'(nm.len());
    for (int k = 0; k < nm.len(); k++) mem[addr+3+k] = nm[k];
    mem[addr+3+nm.len()] = 8'($urandom_range(1, 255));
  endtask

  task automatic preload();
    string tib;
    tib = "123 DUP + 456 -";
    for (int a = 0; a < (1 << ASZ); a++) mem[a] = 8'h00;
    for (int k = 0; k < tib.len(); k++) mem[k] = tib[k];
    mem[15] = 8'h00;
    add_entry('h100, 'hffff, "nop");
    add_entry('h107, 'h100, "dup");
    add_entry('h10E, 'h107, "drop");
    add_entry('h116, 'h10E, "swap");
    add_entry('h11E, 'h116, "+");
    add_entry('h123, 'h11E, "-");
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef FINDER_ICASE_EN
    if (b >= "A" && b <= "Z") return b + 8'h20;
`endif
    return b;
  endfunction

  function automatic res_t model(input logic [ASZ-1:0] t, input logic [ASZ-1:0] c);
    res_t        r;
    int          n;
    logic [16:0] e;
    bit          same;
    r = '0;
    n = 0;
    while (n < 255 && mem[t+n] != 8'h20 && mem[t+n] != 8'h00) n++;
    r.tlen = 8'(n);
    r.nxt  = t + 17'(n);
    e = c;
    if (n > 0) begin
      for (int g = 0; g < 64 && e != 17'h0ffff; g++) begin
        if (int'(mem[e+2]) == n) begin
          same = 1'b1;
          for (int k = 0; k < n; k++)
            if (fold(mem[e+3+k]) != fold(mem[t+k])) same = 1'b0;
          if (same) begin
            r.hit = 1'b1;
            r.pfa = e + 17'(3 + n);
            r.op  = mem[r.pfa];
            return r;
          end
        end
        e = {1'b0, mem[e+1], mem[e]};
      end
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic run_search(input logic [ASZ-1:0] t, input logic [ASZ-1:0] c,
                            output res_t r, output int dones, output logic bsy_seen);
    r     = '0;
    dones = 0;
    @(negedge clk);
    tkn_i = t;
    ctx_i = c;
    en    = 1'b1;
    @(negedge clk);
    en       = 1'b0;
    bsy_seen = bsy;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done === 1'b1) begin
        dones++;
        r = '{hit: hit, pfa: pfa, op: op, tlen: tlen, nxt: nxt};
        break;
      end
      @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bsy, done, hit, pfa, op, tlen, nxt} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h exp 0", {bsy, done, hit, pfa, op, tlen, nxt});
    end
    n_cmp++;
    if ({bus.ai, bus.we} !== '0) begin
      n_bad++;
      $display("FAIL reset_bus got ai=%h we=%b exp 0", bus.ai, bus.we);
    end
    rst = 1'b0;
  endtask

  task automatic test_dup();
    res_t r, exp;
    int   d;
    logic b;
`ifdef FINDER_ICASE_EN
    exp = '{hit: 1'b1, pfa: 17'h10D, op: mem[17'h10D], tlen: 8'd3, nxt: 17'd7};
`else
    exp = '{hit: 1'b0, pfa: 17'h0, op: 8'h0, tlen: 8'd3, nxt: 17'd7};
`endif
    run_search(17'd4, 17'h123, r, d, b);
    n_cmp++;
    if (r !== exp) begin n_bad++; $display("FAIL dup_result got %h exp %h", r, exp); end
    n_cmp++;
    if (b !== 1'b1) begin n_bad++; $display("FAIL dup_bsy got %b exp 1", b); end
    n_cmp++;
    if (d != 1) begin n_bad++; $display("FAIL dup_done_count got %0d exp 1", d); end
  endtask

  task automatic test_plus_minus();
    res_t r, exp;
    int   d;
    logic b;
    exp = '{hit: 1'b1, pfa: 17'h122, op: mem[17'h122], tlen: 8'd1, nxt: 17'd9};
    run_search(17'd8, 17'h123, r, d, b);
    n_cmp++;
    if (r !== exp || d != 1) begin n_bad++; $display("FAIL plus_result got %h/%0d exp %h/1", r, d, exp); end
    exp = '{hit: 1'b1, pfa: 17'h127, op: mem[17'h127], tlen: 8'd1, nxt: 17'd15};
    run_search(17'd14, 17'h123, r, d, b);
    n_cmp++;
    if (r !== exp || d != 1) begin n_bad++; $display("FAIL minus_result got %h/%0d exp %h/1", r, d, exp); end
  endtask

  task automatic test_miss_walk();
    res_t r, exp;
    int   d;
    logic b;
    exp = '{hit: 1'b0, pfa: 17'h0, op: 8'h0, tlen: 8'd3, nxt: 17'd3};
    dict_rd = 0;
    run_search(17'd0, 17'h123, r, d, b);
    n_cmp++;
    if (r !== exp) begin n_bad++; $display("FAIL miss_result got %h exp %h", r, exp); end
    n_cmp++;
    if (d != 1) begin n_bad++; $display("FAIL miss_done_count got %0d exp 1", d); end
    n_cmp++;
    if (dict_rd == 0) begin n_bad++; $display("FAIL miss_walk dict reads got 0 exp >0"); end
  endtask

  task automatic test_no_dict();
    res_t r, exp;
    int   d;
    logic b;
    exp = '{hit: 1'b0, pfa: 17'h0, op: 8'h0, tlen: 8'd3, nxt: 17'd7};
    dict_rd = 0;
    run_search(17'd4, 17'h0ffff, r, d, b);
    n_cmp++;
    if (r !== exp || d != 1) begin n_bad++; $display("FAIL nullctx_result got %h/%0d exp %h/1", r, d, exp); end
    n_cmp++;
    if (dict_rd != 0) begin n_bad++; $display("FAIL nullctx_reads got %0d exp 0", dict_rd); end
    exp = '{hit: 1'b0, pfa: 17'h0, op: 8'h0, tlen: 8'd0, nxt: 17'd3};
    dict_rd = 0;
    run_search(17'd3, 17'h123, r, d, b);
    n_cmp++;
    if (r !== exp || d != 1) begin n_bad++; $display("FAIL emptytok_result got %h/%0d exp %h/1", r, d, exp); end
    n_cmp++;
    if (dict_rd != 0) begin n_bad++; $display("FAIL emptytok_reads got %0d exp 0", dict_rd); end
  endtask

  task automatic test_saturate();
    res_t r, exp;
    int   d;
    logic b;
    for (int k = 0; k < 300; k++) mem['h400+k] = "A";
    mem['h400+300] = 8'h20;
    exp = '{hit: 1'b0, pfa: 17'h0, op: 8'h0, tlen: 8'd255, nxt: 17'h4FF};
    run_search(17'h400, 17'h123, r, d, b);
    n_cmp++;
    if (r !== exp || d != 1) begin n_bad++; $display("FAIL saturate_result got %h/%0d exp %h/1", r, d, exp); end
  endtask

  task automatic test_random();
    res_t        r, exp;
    int          d, j, n;
    logic        b;
    logic [16:0] t, c;
    for (int it = 0; it < 40; it++) begin
      j = $urandom_range(0, 5);
      n = names[j].len();
      for (int k = 0; k < n; k++) begin
        mem['h200+k] = names[j][k];
        if (mem['h200+k] >= "a" && mem['h200+k] <= "z" && $urandom_range(0, 1) == 1)
          mem['h200+k] = mem['h200+k] - 8'h20;
      end
      if ($urandom_range(0, 3) == 0) mem['h200 + $urandom_range(0, n-1)] = "q";
      mem['h200+n] = ($urandom_range(0, 1) == 1) ? 8'h20 : 8'h00;
      t = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(0, 15)) : 17'h200;
      c = ents[$urandom_range(0, 6)];
      exp = model(t, c);
      run_search(t, c, r, d, b);
      n_cmp++;
      if (r !== exp) begin n_bad++; $display("FAIL random_%0d tkn=%h ctx=%h got %h exp %h", it, t, c, r, exp); end
      n_cmp++;
      if (d != 1) begin n_bad++; $display("FAIL random_%0d_done got %0d exp 1", it, d); end
    end
  endtask

  task automatic test_abort();
    res_t r, exp;
    int   d;
    logic b;
    bit   reached;
    @(negedge clk);
    tkn_i = 17'd4;
    ctx_i = 17'h123;
    en    = 1'b1;
    @(negedge clk);
    en      = 1'b0;
    reached = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (dbg_state == 4'd5) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (reached !== 1'b1) begin n_bad++; $display("FAIL abort_reach_cmp got 0 exp 1"); end
    rst = 1'b1;
    d = (done === 1'b1) ? 1 : 0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bsy !== 1'b0) begin n_bad++; $display("FAIL abort_bsy got %b exp 0", bsy); end
    repeat (30) begin
      if (done === 1'b1) d++;
      @(negedge clk);
    end
    n_cmp++;
    if (d != 0) begin n_bad++; $display("FAIL abort_done got %0d exp 0", d); end
    exp = model(17'd4, 17'h123);
    run_search(17'd4, 17'h123, r, d, b);
    n_cmp++;
    if (r !== exp || d != 1) begin n_bad++; $display("FAIL abort_rerun got %h/%0d exp %h/1", r, d, exp); end
  endtask

  task automatic test_back_to_back();
    res_t r, exp;
    int   d;
    logic b;
    exp = '{hit: 1'b1, pfa: 17'h122, op: mem[17'h122], tlen: 8'd1, nxt: 17'd9};
    r = '0;
    d = 0;
    @(negedge clk);
    tkn_i = 17'd8;
    ctx_i = 17'h123;
    en    = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    tkn_i = 17'd14;
    en    = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done === 1'b1) begin
        d++;
        r = '{hit: hit, pfa: pfa, op: op, tlen: tlen, nxt: nxt};
        break;
      end
      @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) d++;
    end
    n_cmp++;
    if (r !== exp || d != 1) begin n_bad++; $display("FAIL busy_en_ignored got %h/%0d exp %h/1", r, d, exp); end
    exp = '{hit: 1'b1, pfa: 17'h127, op: mem[17'h127], tlen: 8'd1, nxt: 17'd15};
    run_search(17'd14, 17'h123, r, d, b);
    n_cmp++;
    if (r !== exp || d != 1) begin n_bad++; $display("FAIL back_to_back got %h/%0d exp %h/1", r, d, exp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    tkn_i = '0;
    ctx_i = '0;
    preload();
    test_reset();
    test_dup();
    test_plus_minus();
    test_miss_walk();
    test_no_dict();
    test_saturate();
    test_random();
    test_abort();
    test_back_to_back();
    n_cmp++;
    if (we_high != 0) begin n_bad++; $display("FAIL we_held_low got %0d high cycles exp 0", we_high); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
